router_pkt_gen: RTL and testbench

Packet transmitter for the 1x3 router's input port. It is the source-side counterpart of the router's input FSM. It builds a complete router packet on `data_out`/`pkt_valid`: a header byte, an LFSR-generated payload, then a parity byte. It honours the router's `busy` back-pressure. It sits ahead of the router in block-level and system benches, and on-chip as a built-in traffic/self-test source.

---
 rtl/router_pkt_gen.sv | 132 +++++++++++++
 tb/tb_router_pkt_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_gen.sv
// Router input-port packet transmitter: header, LFSR payload, parity byte, with busy back-pressure.
// Optional ROUTER_PKT_GEN_BAD_PARITY_EN adds a bad_parity input that inverts the parity byte.
module router_pkt_gen #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [7:0]        seed,
    input  logic              busy,
`ifdef ROUTER_PKT_GEN_BAD_PARITY_EN
    input  logic              bad_parity,
`endif
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_ready,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEADER  = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;
    localparam logic [1:0] PARITY  = 2'd3;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] par;
    logic [DATA_W-1:0] lfsr_next;
    logic [DATA_W-1:0] par_next;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] par_mask;
    logic              last_beat;
    logic              par_flip;

`ifdef ROUTER_PKT_GEN_BAD_PARITY_EN
    logic flip_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            flip_q <= 1'b0;
        else if (state == IDLE && start && dest_addr != 2'd3)
            flip_q <= bad_parity;
    end

    assign par_flip = flip_q;
`else
    assign par_flip = 1'b0;
`endif

    assign tx_ready  = (state == IDLE);
    assign hdr       = {payload_len, dest_addr};
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign par_next  = par ^ lfsr;
    assign par_mask  = {DATA_W{par_flip}};
    // Counter runs 0..len-1, so len=63 finishes at 62 without wrapping.
    assign last_beat = (cnt == len_q - LEN_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            lfsr      <= '0;
            par       <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dest_addr == 2'd3) begin
                            err <= 1'b1;
                        end else begin
                            len_q     <= payload_len;
                            cnt       <= '0;
                            lfsr      <= (seed == 8'h00) ? 8'h01 : seed;
                            par       <= hdr;
                            data_out  <= hdr;
                            pkt_valid <= 1'b1;
                            state     <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        if (len_q != '0) begin
                            data_out <= lfsr;
                            state    <= PAYLOAD;
                        end else begin
                            data_out  <= par ^ par_mask;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        par  <= par_next;
                        lfsr <= lfsr_next;
                        cnt  <= cnt + LEN_W'(1);
                        if (last_beat) begin
                            data_out  <= par_next ^ par_mask;
                            pkt_valid <= 1'b0;
                            state     <= PARITY;
                        end else begin
                            data_out <= lfsr_next;
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        data_out <= '0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed self-checking bench for router_pkt_gen.
// Covers ROUTER_PKT_GEN_BAD_PARITY_EN when the macro is defined.
module tb_router_pkt_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] seed;
    logic       busy;
`ifdef ROUTER_PKT_GEN_BAD_PARITY_EN
    logic       bad_parity;
`endif
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_ready;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    router_pkt_gen #(.DATA_W(8), .LEN_W(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .seed        (seed),
        .busy        (busy),
`ifdef ROUTER_PKT_GEN_BAD_PARITY_EN
        .bad_parity  (bad_parity),
`endif
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .tx_ready    (tx_ready),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] d, input logic pv);
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_pv"}, 32'(pkt_valid), 32'(pv));
    endtask

    task automatic go(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s);
        start       = 1'b1;
        dest_addr   = a;
        payload_len = l;
        seed        = s;
        tick();
        start = 1'b0;
    endtask

    // Reference LFSR step, written from the polynomial taps 7,5,4,3.
    function automatic logic [7:0] ref_step(input logic [7:0] q);
        logic fb;
        fb = q[7] ^ q[5] ^ q[4] ^ q[3];
        return {q[6:0], fb};
    endfunction

    // Basic packet: addr=1 len=3 seed s -> 0D 01 02 04 | 0A.
    task automatic basic_packet(input string tag, input logic [7:0] s);
        go(2'd1, 6'd3, s);
        beat({tag, "_hdr"}, 8'h0D, 1'b1);
        check({tag, "_hdr_rdy"}, 32'(tx_ready), 32'd0);
        tick(); beat({tag, "_p0"}, 8'h01, 1'b1);
        tick(); beat({tag, "_p1"}, 8'h02, 1'b1);
        tick(); beat({tag, "_p2"}, 8'h04, 1'b1);
        tick(); beat({tag, "_par"}, 8'h0A, 1'b0);
        check({tag, "_par_done"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_rdy"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] q, p;
        int         pv_cnt;
        reset = 1'b1; start = 1'b0; busy = 1'b0;
        dest_addr = '0; payload_len = '0; seed = '0;
`ifdef ROUTER_PKT_GEN_BAD_PARITY_EN
        bad_parity = 1'b0;
`endif
        #12;
        beat("rst", 8'h00, 1'b0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdy", 32'(tx_ready), 32'd1);
        @(negedge clock); reset = 1'b0;

        basic_packet("basic", 8'h01);

        // Start in the done cycle: accepted, header next cycle.
        go(2'd2, 6'd0, 8'h05);
        beat("zl_hdr", 8'h02, 1'b1);
        check("zl_hdr_done", 32'(done), 32'd0);
        tick(); beat("zl_par", 8'h02, 1'b0);
        tick(); check("zl_done", 32'(done), 32'd1);

        // Back-pressure on byte 02.
        go(2'd1, 6'd3, 8'h01);
        beat("bp_hdr", 8'h0D, 1'b1);
        tick(); beat("bp_p0", 8'h01, 1'b1);
        tick(); beat("bp_p1", 8'h02, 1'b1);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat($sformatf("bp_hold%0d", i), 8'h02, 1'b1);
            check($sformatf("bp_hold%0d_done", i), 32'(done), 32'd0);
        end
        busy = 1'b0;
        tick(); beat("bp_p2", 8'h04, 1'b1);
        tick(); beat("bp_par", 8'h0A, 1'b0);
        tick(); check("bp_done", 32'(done), 32'd1);
        tick();

        // Illegal address.
        go(2'd3, 6'd4, 8'h11);
        check("ill_err", 32'(err), 32'd1);
        check("ill_pv", 32'(pkt_valid), 32'd0);
        check("ill_rdy", 32'(tx_ready), 32'd1);
        tick();
        check("ill_err_clr", 32'(err), 32'd0);
        check("ill_rdy2", 32'(tx_ready), 32'd1);

        // Reset during second payload byte.
        go(2'd1, 6'd3, 8'h01);
        tick(); beat("mr_p0", 8'h01, 1'b1);
        tick(); beat("mr_p1", 8'h02, 1'b1);
        #2 reset = 1'b1;
        #1;
        beat("mr_rst", 8'h00, 1'b0);
        check("mr_rst_done", 32'(done), 32'd0);
        check("mr_rst_err", 32'(err), 32'd0);
        check("mr_rst_rdy", 32'(tx_ready), 32'd1);
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr_nodone%0d", i), 32'(done), 32'd0);
            check($sformatf("mr_nopv%0d", i), 32'(pkt_valid), 32'd0);
        end
        // Seed 0 is replaced by 01, so the stream matches the basic case.
        basic_packet("after_rst", 8'h00);

        // Maximum length: 64 valid beats, parity from reference model.
        go(2'd0, 6'd63, 8'hA5);
        q = 8'hA5;
        p = 8'hFC;
        pv_cnt = 0;
        for (int i = 0; i < 100 && pkt_valid; i++) begin
            if (i > 0) begin
                if (data_out !== q) check($sformatf("max_p%0d", i - 1), 32'(data_out), 32'(q));
                p = p ^ q;
                q = ref_step(q);
            end
            pv_cnt++;
            tick();
        end
        check("max_pv_beats", 32'(pv_cnt), 32'd64);
        check("max_par", 32'(data_out), 32'(p));
        tick();
        check("max_done", 32'(done), 32'd1);

`ifdef ROUTER_PKT_GEN_BAD_PARITY_EN
        bad_parity = 1'b1;
        go(2'd1, 6'd3, 8'h01);
        bad_parity = 1'b0;
        beat("bad_hdr", 8'h0D, 1'b1);
        tick(); tick(); tick();
        tick(); beat("bad_par", 8'hF5, 1'b0);
        tick(); check("bad_done", 32'(done), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
